command_issuer: RTL and testbench

Upstream feeder for the ALU controller. Buffers 12-bit commands (opcode[11:9], addr1[8:6], addr2[5:3], addr3[2:0]) in a small FIFO. Issues them one at a time as a single-cycle syscall (RUN) pulse with a stable command word. Spaces successive pulses so the controller always finishes its EXECUTE/WRITE_BACK or CAS_WAIT/CAS_SWAP sequence before the next command arrives.

---
 rtl/command_issuer.sv | 119 +++++++++++
 tb/tb_command_issuer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/command_issuer.sv
// Command FIFO feeding the ALU controller one RUN pulse at a time.
// Define ISSUE_STATS_EN to add the issued_count and cas_count outputs.
module command_issuer #(
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              cmd_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     enable,
  input  logic                     flush,
  output logic                     syscall,
  output logic [11:0]              command,
  output logic                     busy,
`ifdef ISSUE_STATS_EN
  output logic [15:0]              issued_count,
  output logic [15:0]              cas_count,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ISSUE_GAP) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] gap_cnt;
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  assign full      = (level == (AW+1)'(DEPTH));
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && enable
                     && (level != '0) && !flush;
  assign syscall   = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  // Storage array; no reset needed, level gates every read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cmd_in;
  end

  // FIFO pointers and occupancy; flush discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
    end
  end

  // Issue sequencer: pop, pulse, then hold off for the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      command <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (pop) begin
            command <= mem[rd_ptr];
            state   <= S_ISSUE;
          end
        end
        (state == S_ISSUE): begin
          gap_cnt <= CW'(ISSUE_GAP - 2);
          state   <= S_WAIT;
        end
        (state == S_WAIT): begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == CW'(1))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  // Saturating issue statistics; survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_count <= '0;
      cas_count    <= '0;
    end else if (state == S_ISSUE) begin
      if (issued_count != 16'hFFFF)
        issued_count <= issued_count + 1'b1;
      if (command[11:9] == 3'b111 && cas_count != 16'hFFFF)
        cas_count <= cas_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_command_issuer.sv
// Randomized scoreboard bench for command_issuer.
// Also checks the stats outputs when ISSUE_STATS_EN is defined.
module tb_command_issuer;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic                    clk = 0;
  logic                    rst_n = 0;
  logic [11:0]             cmd_in = '0;
  logic                    cmd_valid = 0;
  logic                    cmd_ready;
  logic                    enable = 0;
  logic                    flush = 0;
  logic                    syscall;
  logic [11:0]             command;
  logic                    busy;
  logic [$clog2(DEPTH):0]  level;
`ifdef ISSUE_STATS_EN
  logic [15:0]             issued_count;
  logic [15:0]             cas_count;
  int                      m_issued;
  int                      m_cas;
`endif

  command_issuer #(.DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_in(cmd_in),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .enable(enable),
    .flush(flush),
    .syscall(syscall),
    .command(command),
    .busy(busy),
`ifdef ISSUE_STATS_EN
    .issued_count(issued_count),
    .cas_count(cas_count),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int last_issue = -100;
  logic [11:0] last_cmd = '0;
  logic [11:0] q[$];
  logic [11:0] exp_q[$];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               n, act, exp, t);
    end
  endtask

  // Scoreboard monitor: every RUN pulse must carry the next expected word.
  always @(negedge clk) begin
    if (rst_n && syscall) begin
      if (exp_q.size() == 0)
        chk("sb_unexpected_syscall", 1, 0);
      else
        chk("sb_command", int'(command), int'(exp_q.pop_front()));
    end
  end

  // Compare DUT outputs with the reference view of cycle t.
  task automatic check_now();
    int since;
    since = t - last_issue;
    chk("syscall", int'(syscall), int'(since == 0));
    chk("busy", int'(busy), int'(since >= 0 && since < GAP - 1));
    chk("level", int'(level), q.size());
    chk("cmd_ready", int'(cmd_ready),
        int'(q.size() != DEPTH && !flush));
    chk("command_hold", int'(command), int'(last_cmd));
`ifdef ISSUE_STATS_EN
    if (since == 1) begin
      if (m_issued < 65535) m_issued++;
      if (last_cmd[11:9] == 3'b111 && m_cas < 65535) m_cas++;
    end
    chk("issued_count", int'(issued_count), m_issued);
    chk("cas_count", int'(cas_count), m_cas);
`endif
  endtask

  // One cycle: check, drive inputs, advance the reference model.
  task automatic step(input logic v, input logic [11:0] c,
                      input logic en, input logic fl);
    logic idle;
    logic rdy;
    check_now();
    cmd_valid = v;
    cmd_in    = c;
    enable    = en;
    flush     = fl;
    idle = (t - last_issue) >= GAP - 1;
    rdy  = (q.size() != DEPTH) && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (idle && en && q.size() != 0) begin
        last_cmd   = q.pop_front();
        exp_q.push_back(last_cmd);
        last_issue = t + 1;
      end
      if (v && rdy)
        q.push_back(c);
    end
    @(negedge clk);
    t++;
  endtask

  task automatic idle_steps(input int n, input logic en);
    for (int i = 0; i < n; i++) step(0, 12'h000, en, 0);
  endtask

  initial begin
`ifdef ISSUE_STATS_EN
    m_issued = 0;
    m_cas    = 0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    t = 0;
    last_issue = -100;

    // single command latency and hold
    step(1, 12'h0C5, 1, 0);
    idle_steps(8, 1);

    // three back-to-back commands, spaced pulses
    step(1, 12'h011, 1, 0);
    step(1, 12'h252, 1, 0);
    step(1, 12'hE53, 1, 0);
    idle_steps(16, 1);

    // fill while disabled, overflow attempt, then drain
    for (int i = 0; i < DEPTH; i++)
      step(1, 12'(12'h100 + i), 0, 0);
    step(1, 12'hABC, 0, 0);
    step(1, 12'hABD, 0, 0);
    idle_steps(DEPTH * GAP + 6, 1);

    // flush two cycles after the first pulse, push during flush dropped
    step(1, 12'h301, 1, 0);
    step(1, 12'h302, 1, 0);
    step(1, 12'h303, 1, 0);
    step(1, 12'h304, 1, 1);
    step(1, 12'h305, 1, 1);
    idle_steps(10, 1);

    // CAS and plain commands for statistics
    step(1, 12'hE53, 1, 0);
    step(1, 12'h011, 1, 0);
    step(1, 12'hFFF, 1, 0);
    idle_steps(14, 1);

    // async reset mid-WAIT with three still buffered
    for (int i = 0; i < 4; i++)
      step(1, 12'(12'h400 + i), 0, 0);
    step(0, 12'h000, 1, 0);
    step(0, 12'h000, 0, 0);
    check_now();
    rst_n = 0;
    #1;
    chk("rst_syscall", int'(syscall), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_command", int'(command), 0);
    q.delete();
    exp_q.delete();
    last_issue = t - 100;
    last_cmd = '0;
`ifdef ISSUE_STATS_EN
    m_issued = 0;
    m_cas    = 0;
`endif
    @(negedge clk);
    t++;
    rst_n = 1;
    @(negedge clk);
    t++;
    idle_steps(8, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [11:0] c;
      c = 12'($urandom);
      if ($urandom_range(0, 3) == 0) c[11:9] = 3'b111;
      step($urandom_range(0, 9) < 6, c,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 99) < 3);
    end
    idle_steps(DEPTH * GAP + 8, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
